// File: rtl/sdram_load_control.sv
// Layer-start tile loader: copies DEPTH words per enabled channel from SDRAM into the
// three local feature RAMs, one outstanding read at a time, then pulses o_finish.
//
// state  | meaning
// IDLE   | waiting for i_start; bases and mask latched on start
// READ   | one-cycle SDRAM read request for base[ch]+k
// WAIT   | request outstanding, capture data on i_sdramReady
// WRITE  | write captured word to RAM[ch] at index k
// UPDATE | word k done for all channels; advance k or finish
// FINISH | one-cycle done pulse
module sdram_load_control #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  localparam int RAM_AW = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [2:0]        i_chanEn,
  input  logic [ADDR_W-1:0] i_baseAddr0,
  input  logic [ADDR_W-1:0] i_baseAddr1,
  input  logic [ADDR_W-1:0] i_baseAddr2,
  output logic              o_rdSdram,
  output logic [ADDR_W-1:0] o_addrToSdram,
  input  logic              i_sdramReady,
  input  logic [DATA_W-1:0] i_dataFromSdram,
  output logic [2:0]        o_wrRam,
  output logic [RAM_AW-1:0] o_addrToRam,
  output logic [DATA_W-1:0] o_dataToRam,
  output logic              o_busy,
  output logic              o_finish
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, UPDATE, FINISH} state_t;

  state_t            state, stateNext;
  logic [RAM_AW-1:0] k, kNext;
  logic [1:0]        ch, chNext;
  logic [2:0]        mask;
  logic [ADDR_W-1:0] base0, base1, base2;
  logic [DATA_W-1:0] dataReg;
  logic [ADDR_W-1:0] baseSel;

  function automatic logic [1:0] lowestCh(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      k       <= '0;
      ch      <= '0;
      mask    <= '0;
      base0   <= '0;
      base1   <= '0;
      base2   <= '0;
      dataReg <= '0;
    end else begin
      state <= stateNext;
      k     <= kNext;
      ch    <= chNext;
      if (state == IDLE && i_start) begin
        mask  <= i_chanEn;
        base0 <= i_baseAddr0;
        base1 <= i_baseAddr1;
        base2 <= i_baseAddr2;
      end
      if (state == WAIT && i_sdramReady)
        dataReg <= i_dataFromSdram;
    end
  end

  always_comb begin
    stateNext = state;
    kNext     = k;
    chNext    = ch;
    case (state)
      IDLE: begin
        if (i_start) begin
          kNext = '0;
          // live mask here: the latched copy only becomes visible next cycle
          if (i_chanEn != 3'b000) begin
            stateNext = READ;
            chNext    = lowestCh(i_chanEn);
          end else begin
            stateNext = FINISH;
          end
        end
      end
      READ:  stateNext = WAIT;
      WAIT:  if (i_sdramReady) stateNext = WRITE;
      WRITE: begin
        if (ch == 2'd0 && mask[1]) begin
          chNext    = 2'd1;
          stateNext = READ;
        end else if (ch != 2'd2 && mask[2]) begin
          chNext    = 2'd2;
          stateNext = READ;
        end else begin
          stateNext = UPDATE;
        end
      end
      UPDATE: begin
        if (k == RAM_AW'(DEPTH - 1)) begin
          stateNext = FINISH;
        end else begin
          kNext     = k + 1'b1;
          chNext    = lowestCh(mask);
          stateNext = READ;
        end
      end
      FINISH: begin
        kNext     = '0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    case (ch)
      2'd0:    baseSel = base0;
      2'd1:    baseSel = base1;
      default: baseSel = base2;
    endcase
  end

  assign o_rdSdram     = (state == READ);
  assign o_addrToSdram = (state == READ || state == WAIT) ? (baseSel + ADDR_W'(k)) : '0;
  assign o_wrRam       = (state == WRITE) ? (3'b001 << ch) : 3'b000;
  assign o_addrToRam   = k;
  assign o_dataToRam   = dataReg;
  assign o_busy        = (state != IDLE);
  assign o_finish      = (state == FINISH);

endmodule
